// File: rtl/riscv_data_mem_responder.sv
// Memory side of the MEM-stage load/store handshake: one request at a time on req/gnt,
// byte/half/word access to an internal word RAM, one rvalid pulse per accepted request.
module riscv_data_mem_responder #(
    parameter int MEM_WORDS   = 1024,
    parameter int WAIT_CYCLES = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_i,
    output logic        gnt_o,
    input  logic        we_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    input  logic [2:0]  funct3_i,
    output logic        rvalid_o,
    output logic [31:0] rdata_o,
    output logic        err_o
);
    localparam int AW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        we_q, we_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [2:0]  rsp_funct3_q, rsp_funct3_d;
    logic [1:0]  rsp_lane_q, rsp_lane_d;
    logic        rsp_zero_q, rsp_zero_d;
    logic        err_q, err_d;
    logic [31:0] rd_word_q;
    logic [31:0] mem [MEM_WORDS];

    logic          accept, commit, wr_en;
    logic [31:0]   acc_addr, acc_wdata;
    logic          acc_we;
    logic [2:0]    acc_funct3;
    logic          misaligned, bad_funct3, out_of_range, acc_err;
    logic [3:0]    be;
    logic [31:0]   wr_word;
    logic [AW-1:0] idx;
    logic [7:0]    rd_lane [4];
    logic [7:0]    sel_byte;
    logic [15:0]   sel_half;

    // With no wait states the access commits on the accept edge, so it uses the live inputs.
    assign acc_addr   = (WAIT_CYCLES == 0) ? addr_i   : addr_q;
    assign acc_wdata  = (WAIT_CYCLES == 0) ? wdata_i  : wdata_q;
    assign acc_we     = (WAIT_CYCLES == 0) ? we_i     : we_q;
    assign acc_funct3 = (WAIT_CYCLES == 0) ? funct3_i : funct3_q;
    assign idx        = acc_addr[AW+1:2];
    assign accept     = req_i && gnt_o;

    always_comb begin
        misaligned = 1'b0;
        bad_funct3 = 1'b0;
        case (acc_funct3)
            F3_B:    ;
            F3_H:    misaligned = acc_addr[0];
            F3_W:    misaligned = |acc_addr[1:0];
            F3_BU:   bad_funct3 = acc_we;
            F3_HU:   begin bad_funct3 = acc_we; misaligned = acc_addr[0]; end
            default: bad_funct3 = 1'b1;
        endcase
        out_of_range = {2'b00, acc_addr[31:2]} >= 32'(MEM_WORDS);
        acc_err      = misaligned || bad_funct3 || out_of_range;
    end

    always_comb begin
        be      = 4'b1111;
        wr_word = acc_wdata;
        case (acc_funct3[1:0])
            2'b00:   begin be = 4'b0001 << acc_addr[1:0]; wr_word = {4{acc_wdata[7:0]}}; end
            2'b01:   begin be = acc_addr[1] ? 4'b1100 : 4'b0011; wr_word = {2{acc_wdata[15:0]}}; end
            default: ;
        endcase
    end

    // Next-state and datapath updates; the counter holds remaining BUSY cycles minus one.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        we_d         = we_q;
        funct3_d     = funct3_q;
        rsp_funct3_d = rsp_funct3_q;
        rsp_lane_d   = rsp_lane_q;
        rsp_zero_d   = rsp_zero_q;
        err_d        = err_q;
        commit       = 1'b0;
        case (state_q)
            IDLE, RESP: begin
                state_d = IDLE;
                if (accept) begin
                    addr_d   = addr_i;
                    wdata_d  = wdata_i;
                    we_d     = we_i;
                    funct3_d = funct3_i;
                    if (WAIT_CYCLES == 0) begin
                        commit  = 1'b1;
                        state_d = RESP;
                    end else begin
                        cnt_d   = 4'(WAIT_CYCLES - 1);
                        state_d = BUSY;
                    end
                end
            end
            BUSY: begin
                if (cnt_q == 4'd0) begin
                    commit  = 1'b1;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase
        if (commit) begin
            rsp_funct3_d = acc_funct3;
            rsp_lane_d   = acc_addr[1:0];
            rsp_zero_d   = acc_we || acc_err;
            err_d        = acc_err;
        end
    end

    assign wr_en = commit && acc_we && !acc_err && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= 4'd0;
            addr_q       <= '0;
            wdata_q      <= '0;
            we_q         <= 1'b0;
            funct3_q     <= '0;
            rsp_funct3_q <= '0;
            rsp_lane_q   <= '0;
            rsp_zero_q   <= 1'b1;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            we_q         <= we_d;
            funct3_q     <= funct3_d;
            rsp_funct3_q <= rsp_funct3_d;
            rsp_lane_q   <= rsp_lane_d;
            rsp_zero_q   <= rsp_zero_d;
            err_q        <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) mem[idx][8*b +: 8] <= wr_word[8*b +: 8];
            end
        end
        if (commit) rd_word_q <= mem[idx];
    end

    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        assign rd_lane[gi] = rd_word_q[8*gi +: 8];
    end

    always_comb begin
        gnt_o    = !rst && (state_q == IDLE || state_q == RESP);
        rvalid_o = (state_q == RESP);
        err_o    = err_q;
        sel_byte = rd_lane[rsp_lane_q];
        sel_half = rsp_lane_q[1] ? rd_word_q[31:16] : rd_word_q[15:0];
        case (rsp_funct3_q)
            F3_B:    rdata_o = {{24{sel_byte[7]}}, sel_byte};
            F3_H:    rdata_o = {{16{sel_half[15]}}, sel_half};
            F3_BU:   rdata_o = {24'd0, sel_byte};
            F3_HU:   rdata_o = {16'd0, sel_half};
            default: rdata_o = rd_word_q;
        endcase
        if (rsp_zero_q) rdata_o = '0;
    end

endmodule
